sevseg_display_arbiter: RTL and testbench
=========================================

// Module: sevseg_display_arbiter
// PURPOSE
//  Shares the single 4-digit seven-segment display between NREQ requesters, e.g. calculator result or error code.
//  Round-robin grant with a minimum on-screen hold so digits never flicker between owners.
//  Registered 4x4-bit digit values feed the 4-digit multiplexing driver; the driver's own scan is untouched.
// PARAMETERS
//  NREQ      2          number of requesters, legal 2..4
//  MIN_HOLD  1<<20      cycles an owner's digits stay on screen after grant, ~10 ms at 100 MHz
//  MAX_HOLD  1<<27      cycles before a contended owner is preempted; used only with SEVSEG_ARB_TIMEOUT_EN
// PORTS
//  clk       in   1          system clock, 100 MHz
//  reset     in   1          synchronous, active-high
//  req       in   NREQ       level request per requester; held high while it wants the display
//  data      in   NREQ*16    packed digits per requester, [16*i+15:16*i] = {d3,d2,d1,d0}
//  grant     out  NREQ       one-hot owner, all-zero when no owner
//  disp3     out  4          leftmost digit value to driver
//  disp2     out  4          digit value to driver
//  disp1     out  4          digit value to driver
//  disp0     out  4          rightmost digit value to driver
//  busy      out  1          high in OWN or LINGER
// BEHAVIOUR
//  Reset: state=IDLE; grant=0; disp3..disp0=4'h0; busy=0; hold_cnt=0; rr_ptr=0. Reset overrides every other event.
//  FSM states: IDLE, OWN, LINGER.
//   IDLE -> OWN when |req.
//    Winner is the first set req starting at rr_ptr and going upward with wrap.
//    grant is asserted the next cycle; hold_cnt=0.
//   OWN: grant stays. Every cycle disp3..disp0 <= data of the owner, so display latency is 1 cycle from data.
//    hold_cnt increments and saturates at MAX_HOLD.
//    Owner req low with hold_cnt>=MIN_HOLD-1 -> IDLE: grant=0 that cycle, rr_ptr=owner+1 mod NREQ.
//    Owner req low with hold_cnt<MIN_HOLD-1 -> LINGER: grant=0 and disp frozen at its last value.
//   LINGER: hold_cnt keeps counting. At hold_cnt==MIN_HOLD-1 -> IDLE with rr_ptr=owner+1.
//    A re-request by the old owner during LINGER is not special. It competes in IDLE like any other requester.
//  In IDLE, disp keeps the last owner's digits; it is not cleared. busy=0.
//  A new request during OWN/LINGER waits; it is never dropped while req stays high. Requests are not latched.
//  Owner req low in the same cycle another req rises: normal release; the new req wins in IDLE.
//  rr_ptr wraps NREQ-1 -> 0. hold_cnt width is $clog2(MAX_HOLD+1).
//  Minimum IDLE dwell is 1 cycle between owners. Worst-case wait without timeout is unbounded.
//  data of non-owners is ignored. disp only changes in OWN.
// CONFIGURATION
//  SEVSEG_ARB_TIMEOUT_EN defined: in OWN with hold_cnt==MAX_HOLD-1 and any other req high -> IDLE.
//   grant drops, rr_ptr=owner+1, disp keeps its last value.
//   With no contender the owner keeps the display indefinitely.
//  SEVSEG_ARB_TIMEOUT_EN undefined: no preemption; MAX_HOLD only sizes the counter.
// STRUCTURE
//  sevseg_pkg: state enum, typedef logic [3:0] digit_t, typedef digit_t [3:0] disp_t, localparam NREQ_MAX=4.
//  Sub-module sevseg_rr_picker: combinational round-robin picker.
//   Inputs req and ptr; outputs one-hot winner and its index.
//  Top holds the FSM, hold counter, rr_ptr and disp registers.
// TESTING
//  Bench parameters: NREQ=2, MIN_HOLD=4, MAX_HOLD=16.
//  reset mid-OWN (grant=01, disp=1234) -> next cycle grant=00, disp=0000, busy=0, rr_ptr=0.
//  req=01, data0=16'h1234 -> grant=01 after 1 cycle; disp=1,2,3,4 one cycle later.
//   req0 drops after 10 cycles -> grant=00, IDLE.
//  Both req high from reset -> owner 0 first. Req0 drops -> grant=10 after 1 IDLE cycle.
//   Req1 drops -> next grant goes to 0 (rr wrap).
//  req0 pulses high for 2 cycles -> LINGER. Grant drops at once; disp holds until hold_cnt=3; busy low at cycle 4.
//  Timeout on, req=11 held, owner 0 -> preempted at hold_cnt=15 -> grant=10.
//   Timeout off -> grant stays 01 indefinitely.
//  Owner 1 holds; data0 changes from 16'hAAAA to 16'h5555 -> disp unaffected.

Source files
------------

// File: rtl/sevseg_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
// The optional preemption feature is selected in the top with SEVSEG_ARB_TIMEOUT_EN.
package sevseg_pkg;

  localparam int unsigned NREQ_MAX = 4;
  localparam int unsigned IDX_W    = $clog2(NREQ_MAX);
  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned NDIGITS  = 4;
  localparam int unsigned DISP_W   = DIGIT_W * NDIGITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_LINGER
  } state_t;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef digit_t [NDIGITS-1:0] disp_t;

  // Distance of requester idx from the round-robin pointer, walking upward with wrap.
  function automatic int unsigned rr_dist(input int unsigned idx,
                                          input logic [IDX_W-1:0] ptr,
                                          input int unsigned nreq);
    int unsigned p;
    p = 32'(ptr);
    if (idx >= p) return idx - p;
    return idx + nreq - p;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx,
                                                input int unsigned nreq);
    if (32'(idx) + 32'd1 >= nreq) return '0;
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/sevseg_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module sevseg_rr_picker
  import sevseg_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  winner_c,
  output logic [IDX_W-1:0] index_c
);

  logic found;

  // Scan priority distances nearest-first so the loop indices stay constant.
  always_comb begin
    winner_c = '0;
    index_c  = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (rr_dist(i, ptr, NREQ) == k)) begin
          found       = 1'b1;
          winner_c[i] = 1'b1;
          index_c     = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sevseg_display_arbiter.sv
// Round-robin owner arbitration for the shared 4-digit display with a minimum hold.
// Define SEVSEG_ARB_TIMEOUT_EN to preempt a contended owner after MAX_HOLD cycles.
module sevseg_display_arbiter
  import sevseg_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned MIN_HOLD = 1 << 20,
  parameter int unsigned MAX_HOLD = 1 << 27
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DISP_W-1:0] data,
  output logic [NREQ-1:0]        grant,
  output logic [DIGIT_W-1:0]     disp3,
  output logic [DIGIT_W-1:0]     disp2,
  output logic [DIGIT_W-1:0]     disp1,
  output logic [DIGIT_W-1:0]     disp0,
  output logic                   busy
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0] MAX_SAT  = CW'(MAX_HOLD);
`ifdef SEVSEG_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] MAX_LAST = CW'(MAX_HOLD - 1);
`endif

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  disp_t            disp_q, disp_d;
  logic [CW-1:0]    hold_q, hold_d, hold_inc;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  pick_c;
  logic [IDX_W-1:0] pick_idx_c;
  logic             owner_req;
  disp_t            owner_data;

  sevseg_rr_picker #(.NREQ(NREQ)) u_picker (
    .req      (req),
    .ptr      (ptr_q),
    .winner_c (pick_c),
    .index_c  (pick_idx_c)
  );

  // grant_q is one-hot on the owner while in OWN, so it doubles as the data select.
  always_comb begin
    owner_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i]) owner_data = owner_data | disp_t'(data[DISP_W*i +: DISP_W]);
    end
  end

  assign owner_req = |(req & grant_q);
  assign hold_inc  = (hold_q == MAX_SAT) ? hold_q : hold_q + CW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    disp_d  = disp_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;

    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (|req) begin
          state_d = ST_OWN;
          grant_d = pick_c;
          owner_d = pick_idx_c;
          hold_d  = '0;
        end
      end

      ST_OWN: begin
        hold_d = hold_inc;
        if (owner_req) disp_d = owner_data;
        if (!owner_req) begin
          grant_d = '0;
          if (hold_q >= MIN_LAST) begin
            state_d = ST_IDLE;
            ptr_d   = next_ptr(owner_q, NREQ);
          end else begin
            state_d = ST_LINGER;
          end
        end
`ifdef SEVSEG_ARB_TIMEOUT_EN
        else if ((hold_q == MAX_LAST) && |(req & ~grant_q)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = next_ptr(owner_q, NREQ);
        end
`endif
      end

      ST_LINGER: begin
        hold_d = hold_inc;
        if (hold_q >= MIN_LAST) begin
          state_d = ST_IDLE;
          ptr_d   = next_ptr(owner_q, NREQ);
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      disp_q  <= '0;
      hold_q  <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      disp_q  <= disp_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign disp3 = disp_q[3];
  assign disp2 = disp_q[2];
  assign disp1 = disp_q[1];
  assign disp0 = disp_q[0];
  assign busy  = busy_q;

endmodule

// File: tb/tb_sevseg_display_arbiter.sv
// Directed bench for sevseg_display_arbiter with NREQ=2, MIN_HOLD=4, MAX_HOLD=16.
module tb_sevseg_display_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] data;
  logic [1:0]  grant;
  logic [3:0]  disp3, disp2, disp1, disp0;
  logic        busy;

  int errors = 0;
  int checks = 0;

  sevseg_display_arbiter #(.NREQ(2), .MIN_HOLD(4), .MAX_HOLD(16)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .data  (data),
    .grant (grant),
    .disp3 (disp3),
    .disp2 (disp2),
    .disp1 (disp1),
    .disp0 (disp0),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [15:0] exp);
    chk(tag, {16'h0, disp3, disp2, disp1, disp0}, {16'h0, exp});
  endtask

  initial begin
    reset = 1'b1;
    req   = 2'b00;
    data  = 32'h0;
    step(2);
    reset = 1'b0;
    chk("reset_grant", {30'h0, grant}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk_disp("reset_disp", 16'h0000);

    // Single requester: grant after 1 cycle, digits 1 cycle after that.
    req  = 2'b01;
    data = {16'h0000, 16'h1234};
    step(1);
    chk("a_grant", {30'h0, grant}, 32'h1);
    chk("a_busy", {31'h0, busy}, 32'h1);
    chk_disp("a_disp_latency", 16'h0000);
    step(1);
    chk_disp("a_disp", 16'h1234);
    step(8);
    req = 2'b00;
    step(1);
    chk("a_release_grant", {30'h0, grant}, 32'h0);
    chk("a_release_busy", {31'h0, busy}, 32'h0);
    chk_disp("a_idle_keeps_disp", 16'h1234);

    // Reset while owning clears everything and returns rr_ptr to 0.
    req = 2'b01;
    step(2);
    chk("b_grant_pre", {30'h0, grant}, 32'h1);
    reset = 1'b1;
    step(1);
    chk("b_reset_grant", {30'h0, grant}, 32'h0);
    chk("b_reset_busy", {31'h0, busy}, 32'h0);
    chk_disp("b_reset_disp", 16'h0000);

    // Both request: 0 first, then 1 after one IDLE cycle, then wrap to 0.
    reset = 1'b0;
    req   = 2'b11;
    data  = {16'hABCD, 16'h1234};
    step(1);
    chk("c_grant0", {30'h0, grant}, 32'h1);
    step(1);
    chk_disp("c_disp0", 16'h1234);
    step(2);
    req = 2'b10;
    step(1);
    chk("c_idle_gap", {30'h0, grant}, 32'h0);
    step(1);
    chk("c_grant1", {30'h0, grant}, 32'h2);
    data = {16'hABCD, 16'hAAAA};
    step(1);
    chk_disp("c_disp1", 16'hABCD);
    data = {16'hABCD, 16'h5555};
    step(1);
    chk_disp("c_nonowner_ignored", 16'hABCD);
    step(1);
    req = 2'b01;
    step(1);
    chk("c_release1", {30'h0, grant}, 32'h0);
    step(1);
    chk("c_wrap_grant0", {30'h0, grant}, 32'h1);
    step(3);
    req = 2'b00;
    step(1);
    chk("c_release0_busy", {31'h0, busy}, 32'h0);

    // Short pulse: LINGER holds busy and digits until hold_cnt reaches 3.
    req  = 2'b01;
    data = {16'hABCD, 16'h5678};
    step(1);
    chk("d_grant", {30'h0, grant}, 32'h1);
    step(1);
    chk_disp("d_disp", 16'h5678);
    req  = 2'b00;
    data = {16'hABCD, 16'h9999};
    step(1);
    chk("d_linger_grant", {30'h0, grant}, 32'h0);
    chk("d_linger_busy", {31'h0, busy}, 32'h1);
    chk_disp("d_linger_disp", 16'h5678);
    req = 2'b10;
    step(1);
    chk("d_linger_busy2", {31'h0, busy}, 32'h1);
    chk("d_waiter_blocked", {30'h0, grant}, 32'h0);
    step(1);
    chk("d_idle_busy", {31'h0, busy}, 32'h0);
    chk("d_idle_grant", {30'h0, grant}, 32'h0);
    chk_disp("d_idle_disp", 16'h5678);
    step(1);
    chk("d_waiter_granted", {30'h0, grant}, 32'h2);

    // Contended long hold: preempted at hold_cnt=15 only with the timeout build.
    reset = 1'b1;
    req   = 2'b00;
    step(1);
    reset = 1'b0;
    req   = 2'b11;
    step(16);
    chk("e_hold15_grant", {30'h0, grant}, 32'h1);
    step(1);
`ifdef SEVSEG_ARB_TIMEOUT_EN
    chk("e_preempt_grant", {30'h0, grant}, 32'h0);
    step(1);
    chk("e_next_owner", {30'h0, grant}, 32'h2);
`else
    chk("e_no_preempt", {30'h0, grant}, 32'h1);
    step(1);
    chk("e_still_owner", {30'h0, grant}, 32'h1);
`endif
    step(30);
    chk("e_late_grant", {30'h0, grant}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
